// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch front end. Issues one instruction-memory
//               request at a time, buffers returned words toward decode
//               through a one-entry output register backed by one skid
//               entry, and handles branch/jump redirects from execute,
//               including redirects that arrive while a request is still
//               in flight.
//
// Parameters
//   PC_RESET        first fetch address after reset
//
// Ports
//   clk             single clock, all state changes on its rising edge
//   reset           synchronous, active-low
//   ireq_valid      instruction-memory request active
//   ireq_addr       request address (held until iresp_data_ok)
//   iresp_data_ok   memory completed the active request this cycle
//   iresp_data      instruction word, valid with iresp_data_ok
//   redirect_valid  execute resolved a taken branch/jump this cycle
//   redirect_pc     redirect target (bits [1:0] are ignored)
//   out_valid       out_pc/out_raw_instr hold an instruction for decode
//   out_ready       decode accepts the output this cycle
//   out_pc          PC of the presented instruction
//   out_raw_instr   instruction word handed to decode
//
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter logic [63:0] PC_RESET = 64'h8000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        ireq_valid,
    output logic [63:0] ireq_addr,
    input  logic        iresp_data_ok,
    input  logic [31:0] iresp_data,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_pc,
    output logic [31:0] out_raw_instr
);

    // FETCH : request at pc is active, responses are delivered
    // FLUSH : request at pc is active but its response belongs to the
    //         squashed path and is discarded; fetch then resumes at the
    //         pending target
    // HOLD  : output register and skid entry both full, no request issued
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        FLUSH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [63:0] c_PC_STEP = 64'd4;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t      r_state_q,      w_state_d;
    logic [63:0] r_pc_q,         w_pc_d;
    logic [63:0] r_pend_q,       w_pend_d;

    logic        r_out_valid_q,  w_out_valid_d;
    logic [63:0] r_out_pc_q,     w_out_pc_d;
    logic [31:0] r_out_instr_q,  w_out_instr_d;

    logic        r_skid_valid_q, w_skid_valid_d;
    logic [63:0] r_skid_pc_q,    w_skid_pc_d;
    logic [31:0] r_skid_instr_q, w_skid_instr_d;

    // Redirect targets are always word aligned.
    logic [63:0] w_redirect_tgt;
    logic [63:0] w_pc_inc;

    assign w_redirect_tgt = {redirect_pc[63:2], 2'b00};
    assign w_pc_inc       = r_pc_q + c_PC_STEP;

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // The request is gated by reset so that nothing is requested while
    // reset is held; the state register already points at FETCH/PC_RESET
    // for the first cycle after release.
    assign ireq_valid    = reset && (r_state_q != HOLD);
    assign ireq_addr     = r_pc_q;
    assign out_valid     = r_out_valid_q;
    assign out_pc        = r_out_pc_q;
    assign out_raw_instr = r_out_instr_q;

    // ------------------------------------------------------------------
    // Next-state / datapath
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d      = r_state_q;
        w_pc_d         = r_pc_q;
        w_pend_d       = r_pend_q;
        w_out_valid_d  = r_out_valid_q;
        w_out_pc_d     = r_out_pc_q;
        w_out_instr_d  = r_out_instr_q;
        w_skid_valid_d = r_skid_valid_q;
        w_skid_pc_d    = r_skid_pc_q;
        w_skid_instr_d = r_skid_instr_q;

        case (r_state_q)
            FETCH: begin
                if (redirect_valid) begin
                    // Redirect wins over decode acceptance: everything
                    // buffered is on the wrong path.
                    w_out_valid_d  = 1'b0;
                    w_out_pc_d     = 64'd0;
                    w_out_instr_d  = 32'd0;
                    w_skid_valid_d = 1'b0;
                    w_skid_pc_d    = 64'd0;
                    w_skid_instr_d = 32'd0;
                    if (iresp_data_ok) begin
                        // Request completes now, so the new path can be
                        // requested straight away; the word is dropped.
                        w_pc_d = w_redirect_tgt;
                    end else begin
                        // Request cannot be withdrawn: wait it out in
                        // FLUSH, remembering where to go afterwards.
                        w_pend_d  = w_redirect_tgt;
                        w_state_d = FLUSH;
                    end
                end else begin
                    if (r_out_valid_q && out_ready) begin
                        w_out_valid_d = 1'b0;
                    end
                    if (iresp_data_ok) begin
                        w_pc_d = w_pc_inc;
                        if (!r_out_valid_q || out_ready) begin
                            w_out_valid_d = 1'b1;
                            w_out_pc_d    = r_pc_q;
                            w_out_instr_d = iresp_data;
                        end else begin
                            // Decode is stalled with the output full: park
                            // the word and stop requesting until it drains.
                            w_skid_valid_d = 1'b1;
                            w_skid_pc_d    = r_pc_q;
                            w_skid_instr_d = iresp_data;
                            w_state_d      = HOLD;
                        end
                    end
                end
            end

            FLUSH: begin
                // Buffers were emptied on entry and nothing is delivered
                // here, so only the pending target and pc move.
                if (redirect_valid) begin
                    w_pend_d = w_redirect_tgt;
                end
                if (iresp_data_ok) begin
                    w_pc_d    = redirect_valid ? w_redirect_tgt : r_pend_q;
                    w_state_d = FETCH;
                end
            end

            HOLD: begin
                if (redirect_valid) begin
                    w_pc_d         = w_redirect_tgt;
                    w_out_valid_d  = 1'b0;
                    w_out_pc_d     = 64'd0;
                    w_out_instr_d  = 32'd0;
                    w_skid_valid_d = 1'b0;
                    w_skid_pc_d    = 64'd0;
                    w_skid_instr_d = 32'd0;
                    w_state_d      = FETCH;
                end else if (out_ready) begin
                    w_out_valid_d  = 1'b1;
                    w_out_pc_d     = r_skid_pc_q;
                    w_out_instr_d  = r_skid_instr_q;
                    w_skid_valid_d = 1'b0;
                    w_skid_pc_d    = 64'd0;
                    w_skid_instr_d = 32'd0;
                    w_state_d      = FETCH;
                end
            end

            default: begin
                w_state_d = FETCH;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state_q      <= FETCH;
            r_pc_q         <= PC_RESET;
            r_pend_q       <= 64'd0;
            r_out_valid_q  <= 1'b0;
            r_out_pc_q     <= 64'd0;
            r_out_instr_q  <= 32'd0;
            r_skid_valid_q <= 1'b0;
            r_skid_pc_q    <= 64'd0;
            r_skid_instr_q <= 32'd0;
        end else begin
            r_state_q      <= w_state_d;
            r_pc_q         <= w_pc_d;
            r_pend_q       <= w_pend_d;
            r_out_valid_q  <= w_out_valid_d;
            r_out_pc_q     <= w_out_pc_d;
            r_out_instr_q  <= w_out_instr_d;
            r_skid_valid_q <= w_skid_valid_d;
            r_skid_pc_q    <= w_skid_pc_d;
            r_skid_instr_q <= w_skid_instr_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Self-checking bench for fetch_unit. Directed scenarios for
//               streaming, back-pressure, in-flight and coincident
//               redirects, and reset during HOLD, followed by random
//               traffic compared against a transaction-level model
//               (expected fetch address plus a queue of delivered words).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    localparam logic [63:0] c_PC_RESET = 64'h8000_0000;

    logic        clk;
    logic        reset;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_data_ok;
    logic [31:0] iresp_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [31:0] out_raw_instr;

    fetch_unit #(.PC_RESET(c_PC_RESET)) dut (
        .clk           (clk),
        .reset         (reset),
        .ireq_valid    (ireq_valid),
        .ireq_addr     (ireq_addr),
        .iresp_data_ok (iresp_data_ok),
        .iresp_data    (iresp_data),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_pc        (out_pc),
        .out_raw_instr (out_raw_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        m_q[$];      // words fetched but not yet taken by decode
    logic [63:0] m_fetch_pc;  // address of the active/next request
    logic        m_drop;      // active request is on a squashed path
    logic [63:0] m_pend;      // where to go once the squashed request ends

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    function automatic logic model_req();
        return reset && (m_q.size() < 2);
    endfunction

    task automatic begin_cyc(input logic rst_n, input logic rv, input logic [63:0] rpc,
                             input logic dok, input logic ordy);
        @(negedge clk);
        reset          = rst_n;
        redirect_valid = rv;
        redirect_pc    = rpc;
        iresp_data_ok  = dok;
        out_ready      = ordy;
        iresp_data     = $urandom;
        #1;
        chk("ireq_valid", {63'd0, ireq_valid}, {63'd0, model_req()});
        if (model_req()) chk("ireq_addr", ireq_addr, m_fetch_pc);
        chk("out_valid", {63'd0, out_valid}, {63'd0, m_q.size() > 0});
        if (m_q.size() > 0) begin
            chk("out_pc", out_pc, m_q[0].pc);
            chk("out_instr", {32'd0, out_raw_instr}, {32'd0, m_q[0].instr});
        end
    endtask

    // Advance the model across the coming rising edge using the inputs
    // the bench has just driven.
    task automatic end_cyc();
        logic        req;
        logic [63:0] tgt;
        ent_t        e;
        req = model_req();
        tgt = {redirect_pc[63:2], 2'b00};
        if (!reset) begin
            m_q.delete();
            m_fetch_pc = c_PC_RESET;
            m_drop     = 1'b0;
            m_pend     = 64'd0;
        end else if (redirect_valid) begin
            m_q.delete();
            if (req && !iresp_data_ok) begin
                m_drop = 1'b1;
                m_pend = tgt;
            end else begin
                m_fetch_pc = tgt;
                m_drop     = 1'b0;
            end
        end else begin
            if (m_q.size() > 0 && out_ready) void'(m_q.pop_front());
            if (req && iresp_data_ok) begin
                if (m_drop) begin
                    m_fetch_pc = m_pend;
                    m_drop     = 1'b0;
                end else begin
                    e.pc    = m_fetch_pc;
                    e.instr = iresp_data;
                    m_q.push_back(e);
                    m_fetch_pc = m_fetch_pc + 64'd4;
                end
            end
        end
    endtask

    initial begin
        logic        rst_n;
        logic        rv;
        logic [63:0] rpc;
        logic        dok;
        logic        ordy;

        reset = 1'b0; redirect_valid = 1'b0; redirect_pc = 64'd0;
        iresp_data_ok = 1'b0; iresp_data = 32'd0; out_ready = 1'b0;
        m_fetch_pc = c_PC_RESET; m_drop = 1'b0; m_pend = 64'd0;

        // ---- reset ----
        begin_cyc(1'b0, 1'b0, 64'd0, 1'b0, 1'b0); end_cyc();
        begin_cyc(1'b0, 1'b0, 64'd0, 1'b0, 1'b0);
        chk("rst_ireq_valid", {63'd0, ireq_valid}, 64'd0);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_pc", out_pc, 64'd0);
        chk("rst_out_instr", {32'd0, out_raw_instr}, 64'd0);
        end_cyc();

        // ---- back-to-back streaming ----
        begin_cyc(1'b1, 1'b0, 64'd0, 1'b1, 1'b1);
        chk("s1_addr0", ireq_addr, 64'h8000_0000);
        end_cyc();
        begin_cyc(1'b1, 1'b0, 64'd0, 1'b1, 1'b1);
        chk("s1_addr1", ireq_addr, 64'h8000_0004);
        chk("s1_out0", out_pc, 64'h8000_0000);
        end_cyc();
        begin_cyc(1'b1, 1'b0, 64'd0, 1'b1, 1'b1);
        chk("s1_addr2", ireq_addr, 64'h8000_0008);
        chk("s1_out1", out_pc, 64'h8000_0004);
        end_cyc();

        // ---- back-pressure into skid / HOLD ----
        begin_cyc(1'b0, 1'b0, 64'd0, 1'b0, 1'b0); end_cyc();
        begin_cyc(1'b1, 1'b0, 64'd0, 1'b1, 1'b0); end_cyc();
        begin_cyc(1'b1, 1'b0, 64'd0, 1'b1, 1'b0);
        chk("s2_out0", out_pc, 64'h8000_0000);
        end_cyc();
        begin_cyc(1'b1, 1'b0, 64'd0, 1'b0, 1'b0);
        chk("s2_hold_noreq", {63'd0, ireq_valid}, 64'd0);
        chk("s2_hold_out", out_pc, 64'h8000_0000);
        end_cyc();
        begin_cyc(1'b1, 1'b0, 64'd0, 1'b0, 1'b1);
        chk("s2_drain0", out_pc, 64'h8000_0000);
        end_cyc();
        // ---- redirect while 0x80000008 is outstanding ----
        begin_cyc(1'b1, 1'b1, 64'h8000_1000, 1'b0, 1'b1);
        chk("s2_drain1", out_pc, 64'h8000_0004);
        chk("s3_addr_req", ireq_addr, 64'h8000_0008);
        end_cyc();
        begin_cyc(1'b1, 1'b0, 64'd0, 1'b0, 1'b1);
        chk("s3_flush_addr", ireq_addr, 64'h8000_0008);
        chk("s3_flush_outv", {63'd0, out_valid}, 64'd0);
        end_cyc();
        begin_cyc(1'b1, 1'b0, 64'd0, 1'b1, 1'b1); end_cyc();
        // ---- redirect coincident with data_ok ----
        begin_cyc(1'b1, 1'b1, 64'h8000_5000, 1'b1, 1'b1);
        chk("s3_new_addr", ireq_addr, 64'h8000_1000);
        end_cyc();
        // ---- two redirects while flushing, then misaligned target ----
        begin_cyc(1'b1, 1'b1, 64'h8000_2000, 1'b0, 1'b1);
        chk("s4_addr", ireq_addr, 64'h8000_5000);
        end_cyc();
        begin_cyc(1'b1, 1'b1, 64'h8000_3000, 1'b0, 1'b1); end_cyc();
        begin_cyc(1'b1, 1'b0, 64'd0, 1'b1, 1'b1);
        chk("s5_old_addr", ireq_addr, 64'h8000_5000);
        end_cyc();
        begin_cyc(1'b1, 1'b1, 64'h8000_4002, 1'b1, 1'b1);
        chk("s5_last_wins", ireq_addr, 64'h8000_3000);
        end_cyc();
        begin_cyc(1'b1, 1'b0, 64'd0, 1'b1, 1'b0);
        chk("s5_aligned", ireq_addr, 64'h8000_4000);
        end_cyc();
        // ---- reset during HOLD with skid full ----
        begin_cyc(1'b1, 1'b0, 64'd0, 1'b1, 1'b0); end_cyc();
        begin_cyc(1'b0, 1'b0, 64'd0, 1'b0, 1'b0);
        chk("s6_rst_noreq", {63'd0, ireq_valid}, 64'd0);
        end_cyc();
        begin_cyc(1'b1, 1'b0, 64'd0, 1'b0, 1'b0);
        chk("s6_outv", {63'd0, out_valid}, 64'd0);
        chk("s6_addr", ireq_addr, 64'h8000_0000);
        end_cyc();

        // ---- random traffic ----
        for (int i = 0; i < 4000; i++) begin
            rst_n = ($urandom_range(199, 0) != 0);
            rv    = ($urandom_range(7, 0) == 0);
            if ($urandom_range(3, 0) == 0)
                rpc = {32'hFFFF_FFFF, 28'hFFF_FFFF, 4'($urandom_range(15, 0))};
            else
                rpc = {$urandom, $urandom};
            dok   = rst_n && (m_q.size() < 2) && ($urandom_range(1, 0) == 1);
            ordy  = ($urandom_range(2, 0) != 0);
            begin_cyc(rst_n, rv, rpc, dok, ordy);
            end_cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
